counter_mod_updown: RTL and testbench

- Parametrised modulo-N up/down counter. Successor to the fixed 0..7 wrap counter.
- Adds configurable width and modulus, enable, direction, synchronous clear, parallel load, an enable prescaler, and registered wrap/step flags.
- Used as the bit/byte/word index generator in the UART word-assembly path and as a general event counter elsewhere.

---
 rtl/counter_mod_updown.sv | 168 ++++++++++++++++
 tb/tb_counter_mod_updown.sv | 281 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/counter_mod_updown.sv
// -----------------------------------------------------------------------------
// counter_mod_updown
//
// Parametrised modulo-N up/down counter with enable prescaler, synchronous
// clear, clamped parallel load and registered step/wrap flags. Used as the
// bit/byte/word index generator in the UART word-assembly path and as a
// general-purpose event counter.
//
// Parameters:
//   WIDTH    - width of count and load_value (2**WIDTH >= MODULO)
//   MODULO   - count range 0..MODULO-1 (MODULO >= 2)
//   PRESCALE - enable pulses needed per count step (PRESCALE >= 1)
//
// Ports:
//   clk        in   rising-edge clock
//   reset      in   asynchronous reset, active-high
//   clear      in   synchronous clear to 0 (highest synchronous priority)
//   enable     in   count request, sampled every cycle
//   dir        in   1 = count up, 0 = count down (sampled on step cycles)
//   load       in   synchronous parallel load
//   load_value in   value for load, clamped to MODULO-1
//   count      out  current count, registered
//   step       out  registered, high the cycle after a step advanced count
//   wrap       out  registered, high the cycle after count wrapped
//   at_max     out  combinational, count == MODULO-1
//   at_zero    out  combinational, count == 0
//
// Build option:
//   COUNTER_SATURATE_EN - when defined, a step that would wrap holds count at
//   its limit instead; that cycle yields step = 0, wrap = 1 (overflow or
//   underflow attempted).
// -----------------------------------------------------------------------------
module counter_mod_updown #(
   parameter int unsigned WIDTH    = 4,
   parameter int unsigned MODULO   = 8,
   parameter int unsigned PRESCALE = 1
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             clear,
   input  logic             enable,
   input  logic             dir,
   input  logic             load,
   input  logic [WIDTH-1:0] load_value,
   output logic [WIDTH-1:0] count,
   output logic             step,
   output logic             wrap,
   output logic             at_max,
   output logic             at_zero
);

   localparam logic [WIDTH-1:0] MAX_VAL   = WIDTH'(MODULO - 1);
   localparam longint unsigned  RANGE     = 64'd1 << WIDTH;

   logic [WIDTH-1:0] r_count;
   logic             r_step;
   logic             r_wrap;

   logic             w_at_max;
   logic             w_at_zero;
   logic             w_advance;
   logic             w_load_over;
   logic [WIDTH-1:0] w_load_val;
   logic [WIDTH-1:0] w_next_count;
   logic             w_next_step;
   logic             w_next_wrap;

   assign w_at_max  = (r_count == MAX_VAL);
   assign w_at_zero = (r_count == '0);

   // Clamp comparator only exists when load_value can exceed the range.
   generate
      if (RANGE > 64'(MODULO)) begin : g_clamp
         assign w_load_over = (load_value > MAX_VAL);
      end else begin : g_no_clamp
         assign w_load_over = 1'b0;
      end
   endgenerate

   assign w_load_val = w_load_over ? MAX_VAL : load_value;

   // Prescaler: phase is kept while enable is low; clear/load restart it.
   generate
      if (PRESCALE > 1) begin : g_prescale
         localparam int unsigned   PW       = $clog2(PRESCALE);
         localparam logic [PW-1:0] PRE_LAST = PW'(PRESCALE - 1);

         logic [PW-1:0] r_pre;

         always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
               r_pre <= '0;
            end else if (clear || load) begin
               r_pre <= '0;
            end else if (enable) begin
               r_pre <= (r_pre == PRE_LAST) ? '0 : r_pre + PW'(1);
            end
         end

         assign w_advance = enable && !clear && !load && (r_pre == PRE_LAST);
      end else begin : g_no_prescale
         assign w_advance = enable && !clear && !load;
      end
   endgenerate

   // Next state for a step cycle; holds with both flags low otherwise.
   always_comb begin
      w_next_count = r_count;
      w_next_step  = 1'b0;
      w_next_wrap  = 1'b0;
      if (w_advance) begin
         if (dir) begin
            if (w_at_max) begin
`ifdef COUNTER_SATURATE_EN
               w_next_wrap  = 1'b1;
`else
               w_next_count = '0;
               w_next_step  = 1'b1;
               w_next_wrap  = 1'b1;
`endif
            end else begin
               w_next_count = r_count + WIDTH'(1);
               w_next_step  = 1'b1;
            end
         end else begin
            if (w_at_zero) begin
`ifdef COUNTER_SATURATE_EN
               w_next_wrap  = 1'b1;
`else
               w_next_count = MAX_VAL;
               w_next_step  = 1'b1;
               w_next_wrap  = 1'b1;
`endif
            end else begin
               w_next_count = r_count - WIDTH'(1);
               w_next_step  = 1'b1;
            end
         end
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_count <= '0;
         r_step  <= 1'b0;
         r_wrap  <= 1'b0;
      end else if (clear) begin
         r_count <= '0;
         r_step  <= 1'b0;
         r_wrap  <= 1'b0;
      end else if (load) begin
         r_count <= w_load_val;
         r_step  <= 1'b0;
         r_wrap  <= 1'b0;
      end else begin
         r_count <= w_next_count;
         r_step  <= w_next_step;
         r_wrap  <= w_next_wrap;
      end
   end

   assign count   = r_count;
   assign step    = r_step;
   assign wrap    = r_wrap;
   assign at_max  = w_at_max;
   assign at_zero = w_at_zero;

endmodule

// File: tb/tb_counter_mod_updown.sv
// -----------------------------------------------------------------------------
// tb_counter_mod_updown
//
// Directed bench for counter_mod_updown. Four instances share the inputs:
//   u8  : WIDTH=4, MODULO=8,  PRESCALE=1
//   u10 : WIDTH=4, MODULO=10, PRESCALE=1
//   up  : WIDTH=4, MODULO=8,  PRESCALE=3
//   u16 : WIDTH=4, MODULO=16, PRESCALE=1 (full binary range)
// Inputs change 1 ns after a rising edge; outputs are sampled there too.
// -----------------------------------------------------------------------------
module tb_counter_mod_updown;

   logic       clk;
   logic       reset;
   logic       clear;
   logic       enable;
   logic       dir;
   logic       load;
   logic [3:0] load_value;

   logic [3:0] c8, c10, cp, c16;
   logic       s8, s10, sp, s16;
   logic       w8, w10, wp, w16;
   logic       mx8, mx10, mxp, mx16;
   logic       z8, z10, zp, z16;

   int errors = 0;
   int checks = 0;

   counter_mod_updown #(.WIDTH(4), .MODULO(8), .PRESCALE(1)) u8 (
      .clk(clk), .reset(reset), .clear(clear), .enable(enable), .dir(dir),
      .load(load), .load_value(load_value), .count(c8), .step(s8),
      .wrap(w8), .at_max(mx8), .at_zero(z8));

   counter_mod_updown #(.WIDTH(4), .MODULO(10), .PRESCALE(1)) u10 (
      .clk(clk), .reset(reset), .clear(clear), .enable(enable), .dir(dir),
      .load(load), .load_value(load_value), .count(c10), .step(s10),
      .wrap(w10), .at_max(mx10), .at_zero(z10));

   counter_mod_updown #(.WIDTH(4), .MODULO(8), .PRESCALE(3)) up (
      .clk(clk), .reset(reset), .clear(clear), .enable(enable), .dir(dir),
      .load(load), .load_value(load_value), .count(cp), .step(sp),
      .wrap(wp), .at_max(mxp), .at_zero(zp));

   counter_mod_updown #(.WIDTH(4), .MODULO(16), .PRESCALE(1)) u16 (
      .clk(clk), .reset(reset), .clear(clear), .enable(enable), .dir(dir),
      .load(load), .load_value(load_value), .count(c16), .step(s16),
      .wrap(w16), .at_max(mx16), .at_zero(z16));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      clear      = 1'b0;
      load       = 1'b0;
      enable     = 1'b0;
      dir        = 1'b1;
      load_value = 4'd0;
      reset      = 1'b1;
      tick();
      reset      = 1'b0;
   endtask

   task automatic test_reset();
      do_reset();
      checks++; if (c8 !== 4'd0) begin errors++; $display("FAIL reset_count: got %0d expected 0", c8); end
      checks++; if (s8 !== 1'b0) begin errors++; $display("FAIL reset_step: got %b expected 0", s8); end
      checks++; if (w8 !== 1'b0) begin errors++; $display("FAIL reset_wrap: got %b expected 0", w8); end
      checks++; if (z8 !== 1'b1) begin errors++; $display("FAIL reset_at_zero: got %b expected 1", z8); end
      checks++; if (mx8 !== 1'b0) begin errors++; $display("FAIL reset_at_max: got %b expected 0", mx8); end
   endtask

   task automatic test_up_wrap();
      logic [3:0] e8;
      logic [3:0] e16;
      do_reset();
      enable = 1'b1;
      dir    = 1'b1;
      for (int i = 1; i <= 17; i++) begin
         tick();
         e8  = 4'(i % 8);
         e16 = 4'(i % 16);
         checks++; if (c8 !== e8) begin errors++; $display("FAIL up8_count[%0d]: got %0d expected %0d", i, c8, e8); end
         checks++; if (s8 !== 1'b1) begin errors++; $display("FAIL up8_step[%0d]: got %b expected 1", i, s8); end
         checks++; if (w8 !== (e8 == 4'd0)) begin errors++; $display("FAIL up8_wrap[%0d]: got %b expected %b", i, w8, (e8 == 4'd0)); end
         checks++; if (mx8 !== (e8 == 4'd7)) begin errors++; $display("FAIL up8_at_max[%0d]: got %b expected %b", i, mx8, (e8 == 4'd7)); end
         checks++; if (c16 !== e16) begin errors++; $display("FAIL up16_count[%0d]: got %0d expected %0d", i, c16, e16); end
         checks++; if (w16 !== (i == 16)) begin errors++; $display("FAIL up16_wrap[%0d]: got %b expected %b", i, w16, (i == 16)); end
      end
      enable = 1'b0;
      tick();
      checks++; if (c8 !== 4'd1) begin errors++; $display("FAIL up8_hold: got %0d expected 1", c8); end
      checks++; if (s8 !== 1'b0) begin errors++; $display("FAIL up8_hold_step: got %b expected 0", s8); end
   endtask

   task automatic test_down_wrap();
      logic [3:0] exp_c [4];
      logic       exp_w [4];
      exp_c = '{4'd1, 4'd0, 4'd9, 4'd8};
      exp_w = '{1'b0, 1'b0, 1'b1, 1'b0};
      do_reset();
      load       = 1'b1;
      load_value = 4'd2;
      dir        = 1'b0;
      tick();
      load = 1'b0;
      checks++; if (c10 !== 4'd2) begin errors++; $display("FAIL down_load: got %0d expected 2", c10); end
      checks++; if (s10 !== 1'b0) begin errors++; $display("FAIL down_load_step: got %b expected 0", s10); end
      enable = 1'b1;
      for (int i = 0; i < 4; i++) begin
         tick();
         checks++; if (c10 !== exp_c[i]) begin errors++; $display("FAIL down_count[%0d]: got %0d expected %0d", i, c10, exp_c[i]); end
         checks++; if (w10 !== exp_w[i]) begin errors++; $display("FAIL down_wrap[%0d]: got %b expected %b", i, w10, exp_w[i]); end
         checks++; if (s10 !== 1'b1) begin errors++; $display("FAIL down_step[%0d]: got %b expected 1", i, s10); end
         checks++; if (z10 !== (exp_c[i] == 4'd0)) begin errors++; $display("FAIL down_at_zero[%0d]: got %b expected %b", i, z10, (exp_c[i] == 4'd0)); end
         checks++; if (mx10 !== (exp_c[i] == 4'd9)) begin errors++; $display("FAIL down_at_max[%0d]: got %b expected %b", i, mx10, (exp_c[i] == 4'd9)); end
      end
      enable = 1'b0;
      tick();
      checks++; if (c10 !== 4'd8) begin errors++; $display("FAIL down_hold: got %0d expected 8", c10); end
      checks++; if (w10 !== 1'b0) begin errors++; $display("FAIL down_hold_wrap: got %b expected 0", w10); end
   endtask

   task automatic test_prescaler();
      logic [10:0] en_seq;
      logic [10:0] st_seq;
      logic [3:0]  exp_c [11];
      en_seq = 11'b11111001111;
      st_seq = 11'b10010000100;
      exp_c  = '{4'd0, 4'd0, 4'd1, 4'd1, 4'd1, 4'd1, 4'd1, 4'd2, 4'd2, 4'd2, 4'd3};
      do_reset();
      dir = 1'b1;
      for (int i = 0; i < 11; i++) begin
         enable = en_seq[i];
         tick();
         checks++; if (cp !== exp_c[i]) begin errors++; $display("FAIL pre_count[%0d]: got %0d expected %0d", i, cp, exp_c[i]); end
         checks++; if (sp !== st_seq[i]) begin errors++; $display("FAIL pre_step[%0d]: got %b expected %b", i, sp, st_seq[i]); end
      end
      enable = 1'b0;
   endtask

   task automatic test_priority();
      do_reset();
      enable = 1'b1;
      dir    = 1'b1;
      tick(); tick(); tick();
      checks++; if (c8 !== 4'd3) begin errors++; $display("FAIL prio_pre: got %0d expected 3", c8); end
      clear      = 1'b1;
      load       = 1'b1;
      load_value = 4'd5;
      tick();
      checks++; if (c8 !== 4'd0) begin errors++; $display("FAIL prio_clear_count: got %0d expected 0", c8); end
      checks++; if (s8 !== 1'b0) begin errors++; $display("FAIL prio_clear_step: got %b expected 0", s8); end
      checks++; if (c10 !== 4'd0) begin errors++; $display("FAIL prio_clear_c10: got %0d expected 0", c10); end
      clear      = 1'b0;
      enable     = 1'b0;
      load_value = 4'd12;
      tick();
      checks++; if (c8 !== 4'd7) begin errors++; $display("FAIL clamp8: got %0d expected 7", c8); end
      checks++; if (mx8 !== 1'b1) begin errors++; $display("FAIL clamp8_at_max: got %b expected 1", mx8); end
      checks++; if (c10 !== 4'd9) begin errors++; $display("FAIL clamp10: got %0d expected 9", c10); end
      checks++; if (c16 !== 4'd12) begin errors++; $display("FAIL noclamp16: got %0d expected 12", c16); end
      enable     = 1'b1;
      load_value = 4'd5;
      tick();
      checks++; if (c8 !== 4'd5) begin errors++; $display("FAIL load_en_count: got %0d expected 5", c8); end
      checks++; if (s8 !== 1'b0) begin errors++; $display("FAIL load_en_step: got %b expected 0", s8); end
      load = 1'b0;
      tick();
      checks++; if (c8 !== 4'd6) begin errors++; $display("FAIL load_then_step: got %0d expected 6", c8); end
      enable = 1'b0;
   endtask

   task automatic test_dir_change();
      logic       dseq [5];
      logic [3:0] exp_c [5];
      dseq  = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
      exp_c = '{4'd1, 4'd2, 4'd1, 4'd0, 4'd1};
      do_reset();
      enable = 1'b1;
      for (int i = 0; i < 5; i++) begin
         dir = dseq[i];
         tick();
         checks++; if (c8 !== exp_c[i]) begin errors++; $display("FAIL dir_count[%0d]: got %0d expected %0d", i, c8, exp_c[i]); end
      end
      enable = 1'b0;
   endtask

   task automatic test_async_reset();
      do_reset();
      enable = 1'b1;
      dir    = 1'b1;
      for (int i = 0; i < 6; i++) tick();
      checks++; if (c8 !== 4'd6) begin errors++; $display("FAIL areset_pre: got %0d expected 6", c8); end
      enable = 1'b0;
      #2;
      reset = 1'b1;
      #1;
      checks++; if (c8 !== 4'd0) begin errors++; $display("FAIL areset_count: got %0d expected 0", c8); end
      checks++; if (s8 !== 1'b0) begin errors++; $display("FAIL areset_step: got %b expected 0", s8); end
      checks++; if (z8 !== 1'b1) begin errors++; $display("FAIL areset_at_zero: got %b expected 1", z8); end
      #1;
      reset  = 1'b0;
      enable = 1'b1;
      tick();
      checks++; if (c8 !== 4'd1) begin errors++; $display("FAIL areset_resume: got %0d expected 1", c8); end
      checks++; if (s8 !== 1'b1) begin errors++; $display("FAIL areset_resume_step: got %b expected 1", s8); end
      enable = 1'b0;
   endtask

   task automatic test_limits();
      logic [3:0] e_up_c;
      logic       e_up_s;
      logic [3:0] e_dn_c;
      logic       e_dn_s;
`ifdef COUNTER_SATURATE_EN
      e_up_c = 4'd7; e_up_s = 1'b0;
      e_dn_c = 4'd0; e_dn_s = 1'b0;
`else
      e_up_c = 4'd0; e_up_s = 1'b1;
      e_dn_c = 4'd7; e_dn_s = 1'b1;
`endif
      do_reset();
      load       = 1'b1;
      load_value = 4'd6;
      dir        = 1'b1;
      tick();
      load   = 1'b0;
      enable = 1'b1;
      tick();
      checks++; if (c8 !== 4'd7) begin errors++; $display("FAIL lim_up1_count: got %0d expected 7", c8); end
      checks++; if (w8 !== 1'b0) begin errors++; $display("FAIL lim_up1_wrap: got %b expected 0", w8); end
      tick();
      checks++; if (c8 !== e_up_c) begin errors++; $display("FAIL lim_up2_count: got %0d expected %0d", c8, e_up_c); end
      checks++; if (s8 !== e_up_s) begin errors++; $display("FAIL lim_up2_step: got %b expected %b", s8, e_up_s); end
      checks++; if (w8 !== 1'b1) begin errors++; $display("FAIL lim_up2_wrap: got %b expected 1", w8); end
      enable     = 1'b0;
      load       = 1'b1;
      load_value = 4'd1;
      dir        = 1'b0;
      tick();
      load   = 1'b0;
      enable = 1'b1;
      tick();
      checks++; if (c8 !== 4'd0) begin errors++; $display("FAIL lim_dn1_count: got %0d expected 0", c8); end
      checks++; if (s8 !== 1'b1) begin errors++; $display("FAIL lim_dn1_step: got %b expected 1", s8); end
      tick();
      checks++; if (c8 !== e_dn_c) begin errors++; $display("FAIL lim_dn2_count: got %0d expected %0d", c8, e_dn_c); end
      checks++; if (s8 !== e_dn_s) begin errors++; $display("FAIL lim_dn2_step: got %b expected %b", s8, e_dn_s); end
      checks++; if (w8 !== 1'b1) begin errors++; $display("FAIL lim_dn2_wrap: got %b expected 1", w8); end
      enable = 1'b0;
      tick();
      checks++; if (w8 !== 1'b0) begin errors++; $display("FAIL lim_idle_wrap: got %b expected 0", w8); end
      checks++; if (c8 !== e_dn_c) begin errors++; $display("FAIL lim_idle_count: got %0d expected %0d", c8, e_dn_c); end
   endtask

   initial begin
      reset      = 1'b1;
      clear      = 1'b0;
      enable     = 1'b0;
      dir        = 1'b1;
      load       = 1'b0;
      load_value = 4'd0;
      test_reset();
      test_up_wrap();
      test_down_wrap();
      test_prescaler();
      test_priority();
      test_dir_change();
      test_async_reset();
      test_limits();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
